// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands LM/SM instructions into single-register LW/SW
// micro-ops at the fetch stage. Holds the PC until the last micro-op, and
// flags the first micro-op so execute takes the base address from RA.
// Optional micro-op counter: define LCA_MULTI_COUNT_EN to build uop_count.
module lm_sm_sequencer #(
   parameter logic [3:0] LM_OP = 4'b0110,
   parameter logic [3:0] SM_OP = 4'b0111,
   parameter logic [3:0] LW_OP = 4'b0100,
   parameter logic [3:0] SW_OP = 4'b0101
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] if_ir,
   input  logic        hold,
   input  logic        flush,
   output logic        IR_load_mux,
   output logic [15:0] new_IR_multi,
   output logic        first_multiple,
   output logic        pc_write,
   output logic        busy,
   output logic [15:0] uop_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state_q, state_d;
   logic [7:0] mask_q, mask_d;
   logic [2:0] ra_q, ra_d;
   logic       is_sm_q, is_sm_d;

   logic       is_multi;
   logic [7:0] act_mask;
   logic [7:0] rem_mask;
   logic [2:0] act_ra;
   logic       act_sm;
   logic [2:0] low_idx;
   logic       active;

   // State register and captured sequence context.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         ra_q    <= '0;
         is_sm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ra_q    <= ra_d;
         is_sm_q <= is_sm_d;
      end
   end

   // Micro-op selection, output decode and next-state logic.
   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      ra_d           = ra_q;
      is_sm_d        = is_sm_q;
      IR_load_mux    = 1'b0;
      new_IR_multi   = '0;
      first_multiple = 1'b0;
      pc_write       = !hold;
      low_idx        = '0;

      is_multi = (if_ir[15:12] == LM_OP) || (if_ir[15:12] == SM_OP);

      // In IDLE the sequence comes straight from the fetched word; in BUSY
      // from the captured context (if_ir still shows the held LM/SM).
      if (state_q == IDLE) begin
         act_mask = if_ir[7:0];
         act_ra   = if_ir[11:9];
         act_sm   = (if_ir[15:12] == SM_OP);
      end else begin
         act_mask = mask_q;
         act_ra   = ra_q;
         act_sm   = is_sm_q;
      end

      // Scan high to low so the last hit is the lowest set bit.
      for (int unsigned i = 8; i > 0; i--) begin
         if (act_mask[i-1]) low_idx = 3'(i - 1);
      end
      rem_mask = act_mask & (act_mask - 8'd1);

      active = (state_q == BUSY) || (is_multi && (act_mask != 8'h00) && !hold);

      // Reset also forces the outputs, since a fetched LM/SM would otherwise
      // produce a micro-op from IDLE while reset is still low.
      if (!reset) begin
         pc_write = 1'b1;
      end else if (flush) begin
         pc_write = 1'b1;
         state_d  = IDLE;
         mask_d   = '0;
      end else if (active) begin
         IR_load_mux    = 1'b1;
         new_IR_multi   = {(act_sm ? SW_OP : LW_OP), low_idx, act_ra, 6'b000000};
         first_multiple = (state_q == IDLE);
         pc_write       = !hold && (rem_mask == 8'h00);
         if (!hold) begin
            mask_d  = rem_mask;
            ra_d    = act_ra;
            is_sm_d = act_sm;
            state_d = (rem_mask != 8'h00) ? BUSY : IDLE;
         end
      end
   end

   assign busy = (state_q == BUSY);

`ifdef LCA_MULTI_COUNT_EN
   logic [15:0] cnt_q;

   // Count every micro-op actually written into IF/ID; wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (IR_load_mux && !hold && !flush) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign uop_count = cnt_q;
`else
   assign uop_count = '0;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for lm_sm_sequencer: a per-cycle vector
// table plus hand-written reset and counter-wrap sequences.
module tb_lm_sm_sequencer;

   logic        clk;
   logic        reset;
   logic [15:0] if_ir;
   logic        hold;
   logic        flush;
   logic        IR_load_mux;
   logic [15:0] new_IR_multi;
   logic        first_multiple;
   logic        pc_write;
   logic        busy;
   logic [15:0] uop_count;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   typedef struct {
      logic [15:0] ir;
      logic        hold;
      logic        flush;
      logic        mux;
      logic [15:0] uop;
      logic        first;
      logic        pcw;
      logic        busy;
   } vec_t;

   localparam int NV = 31;
   vec_t tbl [NV];

   lm_sm_sequencer #(
      .LM_OP(4'b0110),
      .SM_OP(4'b0111),
      .LW_OP(4'b0100),
      .SW_OP(4'b0101)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .if_ir         (if_ir),
      .hold          (hold),
      .flush         (flush),
      .IR_load_mux   (IR_load_mux),
      .new_IR_multi  (new_IR_multi),
      .first_multiple(first_multiple),
      .pc_write      (pc_write),
      .busy          (busy),
      .uop_count     (uop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_uc();
`ifdef LCA_MULTI_COUNT_EN
      return 16'(exp_cnt);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk_all(input string tag, input logic mux, input logic [15:0] uop,
                          input logic first, input logic pcw, input logic bsy);
      chk({tag, ".mux"},   {15'b0, IR_load_mux},    {15'b0, mux});
      chk({tag, ".uop"},   new_IR_multi,            uop);
      chk({tag, ".first"}, {15'b0, first_multiple}, {15'b0, first});
      chk({tag, ".pcw"},   {15'b0, pc_write},       {15'b0, pcw});
      chk({tag, ".busy"},  {15'b0, busy},           {15'b0, bsy});
      chk({tag, ".cnt"},   uop_count,               exp_uc());
   endtask

   initial begin
      //             ir       hold  flush mux  uop      first pcw  busy
      // basic LM: RA=3, list R0,R2,R5
      tbl[0]  = '{16'h6625, 1'b0, 1'b0, 1'b1, 16'h40C0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{16'h6625, 1'b0, 1'b0, 1'b1, 16'h44C0, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{16'h6625, 1'b0, 1'b0, 1'b1, 16'h4AC0, 1'b0, 1'b1, 1'b1};
      // single-register SM, back to back
      tbl[3]  = '{16'h7280, 1'b0, 1'b0, 1'b1, 16'h5E40, 1'b1, 1'b1, 1'b0};
      // empty list passes through
      tbl[4]  = '{16'h6600, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{16'h6600, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      // hold mid-sequence
      tbl[7]  = '{16'h6625, 1'b0, 1'b0, 1'b1, 16'h40C0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{16'h6625, 1'b1, 1'b0, 1'b1, 16'h44C0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{16'h6625, 1'b1, 1'b0, 1'b1, 16'h44C0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{16'h6625, 1'b0, 1'b0, 1'b1, 16'h44C0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{16'h6625, 1'b0, 1'b0, 1'b1, 16'h4AC0, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{16'h7280, 1'b0, 1'b0, 1'b1, 16'h5E40, 1'b1, 1'b1, 1'b0};
      // flush and hold in IDLE with an LM present
      tbl[13] = '{16'h6625, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{16'h6625, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      // list FF, flushed on the 3rd micro-op
      tbl[15] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h40C0, 1'b1, 1'b0, 1'b0};
      tbl[16] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h42C0, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{16'h66FF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
      tbl[18] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      // list FF complete: R0 .. R7
      tbl[19] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h40C0, 1'b1, 1'b0, 1'b0};
      tbl[20] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h42C0, 1'b0, 1'b0, 1'b1};
      tbl[21] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h44C0, 1'b0, 1'b0, 1'b1};
      tbl[22] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h46C0, 1'b0, 1'b0, 1'b1};
      tbl[23] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h48C0, 1'b0, 1'b0, 1'b1};
      tbl[24] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h4AC0, 1'b0, 1'b0, 1'b1};
      tbl[25] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h4CC0, 1'b0, 1'b0, 1'b1};
      tbl[26] = '{16'h66FF, 1'b0, 1'b0, 1'b1, 16'h4EC0, 1'b0, 1'b1, 1'b1};
      tbl[27] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
      // SM RA=7 list R0,R1; if_ir ignored while BUSY
      tbl[28] = '{16'h7E03, 1'b0, 1'b0, 1'b1, 16'h51C0, 1'b1, 1'b0, 1'b0};
      tbl[29] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h53C0, 1'b0, 1'b1, 1'b1};
      tbl[30] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

      // reset with an LM already on the fetch bus
      reset = 1'b0;
      hold  = 1'b0;
      flush = 1'b0;
      if_ir = 16'h6625;
      #12;
      chk_all("reset", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if_ir = tbl[i].ir;
         hold  = tbl[i].hold;
         flush = tbl[i].flush;
         #1;
         chk_all($sformatf("v%0d", i), tbl[i].mux, tbl[i].uop, tbl[i].first,
                 tbl[i].pcw, tbl[i].busy);
         if (tbl[i].mux && !tbl[i].hold && !tbl[i].flush) exp_cnt++;
         @(negedge clk);
      end

      // reset asserted on the 3rd micro-op of an FF list
      if_ir = 16'h66FF;
      hold  = 1'b0;
      flush = 1'b0;
      #1;
      chk_all("rs0", 1'b1, 16'h40C0, 1'b1, 1'b0, 1'b0);
      exp_cnt++;
      @(negedge clk);
      exp_cnt++;
      @(negedge clk);
      #1;
      chk_all("rs2", 1'b1, 16'h44C0, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      exp_cnt = 0;
      #1;
      chk_all("rs_low", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_all("rs_restart", 1'b1, 16'h40C0, 1'b1, 1'b0, 1'b0);
      exp_cnt++;
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk_all("rs_flush", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      if_ir = 16'h0000;
      #1;
      chk_all("rs_idle", 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

`ifdef LCA_MULTI_COUNT_EN
      // drive micro-ops until the count sits at FFFF, then one more wraps
      if_ir = 16'h66FF;
      while (exp_cnt < 65535) begin
         @(negedge clk);
         exp_cnt++;
      end
      #1;
      chk("cnt_max", uop_count, 16'hFFFF);
      @(negedge clk);
      #1;
      chk("cnt_wrap", uop_count, 16'h0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
